// File: rtl/rvfi_commit_tracker.sv
// Commit-side RVFI tracker: checks lane packing, order and PC chaining, detects
// the halt idiom and measures instruction/cycle counts between start/stop markers.
module rvfi_commit_tracker #(
  parameter int unsigned NRET       = 2,
  parameter int unsigned CNT_W      = 48,
  parameter logic [31:0] START_INST = 32'h00102013,
  parameter logic [31:0] STOP_INST  = 32'h00202013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NRET-1:0]    valid,
  input  logic [NRET*64-1:0] order,
  input  logic [NRET*32-1:0] inst,
  input  logic [NRET*32-1:0] pc_rdata,
  input  logic [NRET*32-1:0] pc_wdata,
  input  logic [NRET*4-1:0]  mem_rmask,
  input  logic [NRET*4-1:0]  mem_wmask,
  output logic               halt,
  output logic [3:0]         err_code,
  output logic [63:0]        err_order,
  output logic [CNT_W-1:0]   seg_inst,
  output logic [CNT_W-1:0]   seg_cycles,
  output logic               seg_active,
  output logic               seg_done
);
  localparam logic [1:0] WAIT_FIRST = 2'd0;
  localparam logic [1:0] RUN        = 2'd1;
  localparam logic [1:0] HALTED     = 2'd2;
  localparam logic [1:0] SEG_OFF    = 2'd0;
  localparam logic [1:0] SEG_ON     = 2'd1;
  localparam logic [1:0] SEG_DONE   = 2'd2;
  localparam int unsigned LW = $clog2(NRET + 1);

  logic [1:0]       r_state;
  logic [1:0]       r_seg_state;
  logic [63:0]      r_exp_order;
  logic [31:0]      r_last_pc;
  logic             r_halt;
  logic [3:0]       r_err_code;
  logic [63:0]      r_err_order;
  logic [CNT_W-1:0] r_seg_inst;
  logic [CNT_W-1:0] r_seg_cycles;
  logic             r_seg_done;

  logic [NRET-1:0]  w_cmask;
  logic [NRET-1:0]  w_gap;
  logic [LW-1:0]    w_ncont;
  logic             w_run;
  logic [NRET-1:0]  w_ord_err;
  logic [NRET-1:0]  w_pc_err;
  logic [NRET-1:0]  w_msk_err;
  logic [NRET-1:0]  w_off;
  logic [31:0]      w_prev_pc;
  logic             w_chk_pc;
  logic             w_halt_hit;
  logic [3:0]       w_err;
  logic [63:0]      w_first_order;
  logic             w_found;
  logic [1:0]       w_seg_st;
  logic [LW-1:0]    w_seg_cnt;
  logic             w_seg_start;
  logic             w_seg_stop;
  logic [CNT_W:0]   w_inst_sum;
  logic [CNT_W:0]   w_cyc_sum;
  logic [CNT_W-1:0] w_inst_next;
  logic [CNT_W-1:0] w_cyc_next;

  // The lowest non-contiguous valid lane always has an invalid lane just below
  // it, so valid & ~contiguous flags the same first offender as valid[i-1]==0.
  always_comb begin
    w_cmask = '0;
    w_gap   = '0;
    w_ncont = '0;
    w_run   = 1'b1;
    for (int unsigned i = 0; i < NRET; i++) begin
      w_run      = w_run & valid[i];
      w_cmask[i] = w_run;
      w_gap[i]   = valid[i] & ~w_run;
      if (w_run) w_ncont = w_ncont + 1'b1;
    end
  end

  always_comb begin
    w_prev_pc  = r_last_pc;
    w_chk_pc   = (r_state != WAIT_FIRST);
    w_halt_hit = 1'b0;
    w_ord_err  = '0;
    w_pc_err   = '0;
    w_msk_err  = '0;
    for (int unsigned i = 0; i < NRET; i++) begin
      if (w_cmask[i]) begin
        w_ord_err[i] = (order[i*64 +: 64] != (r_exp_order + 64'(i)));
        w_pc_err[i]  = w_chk_pc && (pc_rdata[i*32 +: 32] != w_prev_pc);
        w_msk_err[i] = (|mem_rmask[i*4 +: 4]) && (|mem_wmask[i*4 +: 4]);
        if ((pc_rdata[i*32 +: 32] == pc_wdata[i*32 +: 32]) ||
            (inst[i*32 +: 32] == 32'h00000063) ||
            (inst[i*32 +: 32] == 32'h0000006f) ||
            (inst[i*32 +: 32] == 32'hF0002013))
          w_halt_hit = 1'b1;
        w_prev_pc = pc_wdata[i*32 +: 32];
        w_chk_pc  = 1'b1;
      end
    end
  end

  always_comb begin
    w_off         = w_gap | w_ord_err | w_pc_err | w_msk_err;
    w_err         = {|w_msk_err, |w_pc_err, |w_ord_err, |w_gap};
    w_found       = 1'b0;
    w_first_order = '0;
    for (int unsigned i = 0; i < NRET; i++) begin
      if (w_off[i] && !w_found) begin
        w_found       = 1'b1;
        w_first_order = order[i*64 +: 64];
      end
    end
  end

  // Markers are resolved in lane order so a start after a stop restarts.
  always_comb begin
    w_seg_st    = r_seg_state;
    w_seg_cnt   = '0;
    w_seg_start = 1'b0;
    w_seg_stop  = 1'b0;
    for (int unsigned i = 0; i < NRET; i++) begin
      if (w_cmask[i]) begin
        if (inst[i*32 +: 32] == START_INST) begin
          w_seg_st    = SEG_ON;
          w_seg_cnt   = '0;
          w_seg_start = 1'b1;
          w_seg_stop  = 1'b0;
        end else if (w_seg_st == SEG_ON) begin
          w_seg_cnt = w_seg_cnt + 1'b1;
          if (inst[i*32 +: 32] == STOP_INST) begin
            w_seg_st   = SEG_DONE;
            w_seg_stop = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_inst_sum  = w_seg_start ? (CNT_W+1)'(w_seg_cnt)
                              : {1'b0, r_seg_inst} + (CNT_W+1)'(w_seg_cnt);
    w_cyc_sum   = {1'b0, r_seg_cycles} + (CNT_W+1)'(1);
    w_inst_next = w_inst_sum[CNT_W] ? '1 : w_inst_sum[CNT_W-1:0];
    w_cyc_next  = w_cyc_sum[CNT_W]  ? '1 : w_cyc_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= WAIT_FIRST;
      r_seg_state  <= SEG_OFF;
      r_exp_order  <= '0;
      r_last_pc    <= '0;
      r_halt       <= 1'b0;
      r_err_code   <= '0;
      r_err_order  <= '0;
      r_seg_inst   <= '0;
      r_seg_cycles <= '0;
      r_seg_done   <= 1'b0;
    end else begin
      if (w_halt_hit)
        r_state <= HALTED;
      else if ((r_state == WAIT_FIRST) && (|valid))
        r_state <= RUN;
      r_halt     <= r_halt | w_halt_hit;
      r_err_code <= r_err_code | w_err;
      if ((r_err_code == '0) && (w_err != '0))
        r_err_order <= w_first_order;
      r_exp_order <= r_exp_order + 64'(w_ncont);
      r_last_pc   <= w_prev_pc;
      r_seg_state <= w_seg_st;
      r_seg_done  <= w_seg_stop;
      if (w_seg_start) begin
        r_seg_cycles <= '0;
        r_seg_inst   <= w_inst_next;
      end else if (r_seg_state == SEG_ON) begin
        r_seg_cycles <= w_cyc_next;
        r_seg_inst   <= w_inst_next;
      end
    end
  end

  assign halt       = r_halt;
  assign err_code   = r_err_code;
  assign err_order  = r_err_order;
  assign seg_inst   = r_seg_inst;
  assign seg_cycles = r_seg_cycles;
  assign seg_active = (r_seg_state == SEG_ON);
  assign seg_done   = r_seg_done;
endmodule

// File: tb/tb_rvfi_commit_tracker.sv
// Randomized and directed bench for rvfi_commit_tracker against a lane-level
// reference model of the commit checking and segment measurement rules.
module tb_rvfi_commit_tracker;
  localparam int unsigned NRET  = 2;
  localparam int unsigned CNT_W = 6;
  localparam logic [31:0] START_I = 32'h00102013;
  localparam logic [31:0] STOP_I  = 32'h00202013;
  localparam logic [31:0] NOP_I   = 32'h00000013;
  localparam longint unsigned MAXC = (64'd1 << CNT_W) - 64'd1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        t_valid [NRET];
  logic [63:0] t_order [NRET];
  logic [31:0] t_inst  [NRET];
  logic [31:0] t_pcr   [NRET];
  logic [31:0] t_pcw   [NRET];
  logic [3:0]  t_rm    [NRET];
  logic [3:0]  t_wm    [NRET];

  logic [NRET-1:0]    valid;
  logic [NRET*64-1:0] order;
  logic [NRET*32-1:0] inst, pc_rdata, pc_wdata;
  logic [NRET*4-1:0]  mem_rmask, mem_wmask;
  logic               halt, seg_active, seg_done;
  logic [3:0]         err_code;
  logic [63:0]        err_order;
  logic [CNT_W-1:0]   seg_inst, seg_cycles;

  always_comb begin
    valid = '0; order = '0; inst = '0; pc_rdata = '0; pc_wdata = '0;
    mem_rmask = '0; mem_wmask = '0;
    for (int i = 0; i < NRET; i++) begin
      valid[i]            = t_valid[i];
      order[i*64 +: 64]   = t_order[i];
      inst[i*32 +: 32]    = t_inst[i];
      pc_rdata[i*32 +: 32] = t_pcr[i];
      pc_wdata[i*32 +: 32] = t_pcw[i];
      mem_rmask[i*4 +: 4] = t_rm[i];
      mem_wmask[i*4 +: 4] = t_wm[i];
    end
  end

  rvfi_commit_tracker #(.NRET(NRET), .CNT_W(CNT_W), .START_INST(START_I), .STOP_INST(STOP_I)) dut (
    .clk(clk), .rst(rst), .valid(valid), .order(order), .inst(inst),
    .pc_rdata(pc_rdata), .pc_wdata(pc_wdata), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
    .halt(halt), .err_code(err_code), .err_order(err_order), .seg_inst(seg_inst),
    .seg_cycles(seg_cycles), .seg_active(seg_active), .seg_done(seg_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit              m_seen, m_halt, m_seg_on, m_done;
  logic [3:0]      m_err;
  logic [63:0]     m_err_order, m_exp;
  logic [31:0]     m_last_pc;
  longint unsigned m_si, m_sc;

  // Stimulus generator state
  logic [63:0] g_order;
  logic [31:0] g_pc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint unsigned sat(input longint unsigned x);
    return (x > MAXC) ? MAXC : x;
  endfunction

  function automatic bit is_halt_inst(input logic [31:0] w);
    return (w == 32'h00000063) || (w == 32'h0000006f) || (w == 32'hF0002013);
  endfunction

  function automatic void model_reset();
    m_seen = 0; m_halt = 0; m_seg_on = 0; m_done = 0;
    m_err = '0; m_err_order = '0; m_exp = '0; m_last_pc = '0;
    m_si = 0; m_sc = 0;
  endfunction

  function automatic void model_cycle();
    int k, counted;
    logic [3:0] e;
    bit found, bad, on, restart, stopped;
    logic [63:0] fo;
    logic [31:0] prev;
    if (!rst) begin
      model_reset();
      return;
    end
    k = 0;
    while (k < NRET && t_valid[k]) k++;
    e = '0; found = 0; fo = '0;
    for (int i = 0; i < NRET; i++) begin
      bad = 0;
      if (i < k) begin
        prev = (i == 0) ? m_last_pc : t_pcw[i-1];
        if (t_order[i] != m_exp + 64'(i)) begin e[1] = 1; bad = 1; end
        if ((i > 0 || m_seen) && t_pcr[i] != prev) begin e[2] = 1; bad = 1; end
        if (t_rm[i] != 0 && t_wm[i] != 0) begin e[3] = 1; bad = 1; end
        if (t_pcr[i] == t_pcw[i] || is_halt_inst(t_inst[i])) m_halt = 1;
      end else if (i > 0 && t_valid[i] && !t_valid[i-1]) begin
        e[0] = 1; bad = 1;
      end
      if (bad && !found) begin found = 1; fo = t_order[i]; end
    end
    if (m_err == 0 && e != 0) m_err_order = fo;
    m_err = m_err | e;
    m_exp = m_exp + 64'(k);
    if (k > 0) m_last_pc = t_pcw[k-1];
    for (int i = 0; i < NRET; i++) if (t_valid[i]) m_seen = 1;
    // segment measurement
    on = m_seg_on; restart = 0; stopped = 0; counted = 0;
    for (int i = 0; i < k; i++) begin
      if (t_inst[i] == START_I) begin
        on = 1; counted = 0; restart = 1; stopped = 0;
      end else if (on) begin
        counted++;
        if (t_inst[i] == STOP_I) begin on = 0; stopped = 1; end
      end
    end
    if (restart) begin
      m_sc = 0; m_si = sat(longint'(counted));
    end else if (m_seg_on) begin
      m_sc = sat(m_sc + 1); m_si = sat(m_si + longint'(counted));
    end
    m_seg_on = on;
    m_done = stopped;
  endfunction

  task automatic step();
    @(posedge clk);
    model_cycle();
    #1;
    chk("halt", 64'(halt), 64'(m_halt));
    chk("err_code", 64'(err_code), 64'(m_err));
    chk("err_order", err_order, m_err_order);
    chk("seg_inst", 64'(seg_inst), 64'(m_si));
    chk("seg_cycles", 64'(seg_cycles), 64'(m_sc));
    chk("seg_active", 64'(seg_active), 64'(m_seg_on));
    chk("seg_done", 64'(seg_done), 64'(m_done));
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < NRET; i++) begin
      t_valid[i] = 0; t_order[i] = '0; t_inst[i] = '0;
      t_pcr[i] = '0; t_pcw[i] = '0; t_rm[i] = '0; t_wm[i] = '0;
    end
  endtask

  task automatic good_lane(input int l, input logic [31:0] ins);
    t_valid[l] = 1; t_order[l] = g_order; t_inst[l] = ins;
    t_pcr[l] = g_pc; t_pcw[l] = g_pc + 32'd4;
    t_rm[l] = '0; t_wm[l] = '0;
    if ($urandom_range(0, 1) == 1) t_rm[l] = 4'($urandom_range(1, 15));
    else t_wm[l] = 4'($urandom_range(0, 15));
    g_order = g_order + 64'd1;
    g_pc = g_pc + 32'd4;
  endtask

  task automatic do_reset(input int n);
    clear_lanes();
    rst = 0;
    repeat (n) step();
    rst = 1;
    g_order = '0;
    g_pc = 32'h0000_1000;
  endtask

  function automatic logic [31:0] pick_inst();
    int r;
    r = $urandom_range(0, 599);
    if (r < 4) return START_I;
    if (r < 6) return STOP_I;
    if (r == 7) return 32'h0000006f;
    if (r < 300) return NOP_I;
    return $urandom & 32'hFFFF_FF7F;
  endfunction

  initial begin
    logic [63:0] saved;
    bit [1:0] vm;
    int r;
    model_reset();
    clear_lanes();
    g_order = '0;
    g_pc = 32'h0000_1000;
    do_reset(2);
    chk("rst_err", 64'(err_code), 64'd0);
    chk("rst_seg_active", 64'(seg_active), 64'd0);

    // dual commits, orders 0..19, consistent PC chain
    repeat (10) begin
      clear_lanes(); good_lane(0, NOP_I); good_lane(1, NOP_I); step();
    end
    chk("dual_err", 64'(err_code), 64'd0);
    chk("dual_halt", 64'(halt), 64'd0);
    clear_lanes(); good_lane(0, NOP_I); good_lane(1, NOP_I); step();
    chk("order20_ok", 64'(err_code), 64'd0);

    // lane gap
    clear_lanes(); good_lane(1, NOP_I); saved = t_order[1]; step();
    chk("gap_err", 64'(err_code), 64'd1);
    chk("gap_order", err_order, saved);

    // order mismatch then PC break
    do_reset(1);
    repeat (2) begin
      clear_lanes(); good_lane(0, NOP_I); good_lane(1, NOP_I); step();
    end
    clear_lanes(); good_lane(0, NOP_I); t_order[0] = 64'd5; step();
    chk("ord_err", 64'(err_code), 64'd2);
    chk("ord_order", err_order, 64'd5);
    clear_lanes(); good_lane(0, NOP_I); t_pcr[0] = 32'hDEAD_0000; step();
    chk("pc_err", 64'(err_code), 64'd6);
    chk("pc_order_held", err_order, 64'd5);

    // segment of 9 single commits ending on the stop marker
    do_reset(1);
    clear_lanes(); good_lane(0, NOP_I); good_lane(1, START_I); step();
    chk("seg_start_active", 64'(seg_active), 64'd1);
    chk("seg_start_cycles", 64'(seg_cycles), 64'd0);
    for (int j = 0; j < 9; j++) begin
      clear_lanes(); good_lane(0, (j == 8) ? STOP_I : NOP_I); step();
    end
    chk("seg9_inst", 64'(seg_inst), 64'd9);
    chk("seg9_cycles", 64'(seg_cycles), 64'd9);
    chk("seg9_done", 64'(seg_done), 64'd1);
    chk("seg9_active", 64'(seg_active), 64'd0);
    clear_lanes(); step();
    chk("seg9_done_pulse", 64'(seg_done), 64'd0);
    chk("seg9_hold", 64'(seg_inst), 64'd9);

    // stop and start in the same cycle restarts
    clear_lanes(); good_lane(0, START_I); step();
    repeat (3) begin
      clear_lanes(); good_lane(0, NOP_I); good_lane(1, NOP_I); step();
    end
    chk("restart_pre_inst", 64'(seg_inst), 64'd6);
    clear_lanes(); good_lane(0, STOP_I); good_lane(1, START_I); step();
    chk("restart_inst", 64'(seg_inst), 64'd0);
    chk("restart_active", 64'(seg_active), 64'd1);
    chk("restart_done", 64'(seg_done), 64'd0);

    // saturation of both counters
    repeat (70) begin
      clear_lanes(); good_lane(0, NOP_I); good_lane(1, NOP_I); step();
    end
    chk("sat_inst", 64'(seg_inst), MAXC);
    chk("sat_cycles", 64'(seg_cycles), MAXC);

    // halt idiom, then a one-cycle reset mid-segment
    clear_lanes(); good_lane(0, 32'h0000006f); step();
    chk("halt_set", 64'(halt), 64'd1);
    clear_lanes(); good_lane(0, NOP_I); rst = 0; step(); rst = 1;
    chk("mid_rst_halt", 64'(halt), 64'd0);
    chk("mid_rst_active", 64'(seg_active), 64'd0);
    chk("mid_rst_inst", 64'(seg_inst), 64'd0);
    g_order = '0; g_pc = 32'h0000_4444;
    clear_lanes(); good_lane(0, NOP_I); step();
    chk("wait_first_skip", 64'(err_code), 64'd0);
    chk("seg_off_hold", 64'(seg_cycles), 64'd0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      clear_lanes();
      if ($urandom_range(0, 199) == 0) begin
        rst = 0; g_order = '0; g_pc = $urandom & 32'hFFFF_FFFC;
      end else begin
        rst = 1;
      end
      r = $urandom_range(0, 99);
      vm = (r < 3) ? 2'b10 : (r < 25) ? 2'b00 : (r < 55) ? 2'b01 : 2'b11;
      for (int l = 0; l < NRET; l++) if (vm[l]) good_lane(l, pick_inst());
      r = $urandom_range(0, 199);
      if (r == 0) t_order[0] = t_order[0] + 64'd1;
      else if (r == 1) t_pcr[NRET-1] = t_pcr[NRET-1] ^ 32'h10;
      else if (r == 2) begin t_rm[0] = 4'h1; t_wm[0] = 4'h2; end
      else if (r == 3) t_pcw[0] = t_pcr[0];
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rvfi_commit_tracker.md
# rvfi_commit_tracker

Synthesizable, parametrised commit tracker for an NRET-wide retirement interface (RVFI subset) that sits beside the core's commit stage, in both simulation and FPGA builds. It checks lane packing, order sequencing and PC chaining across lanes and cycles. It also detects the halt idiom and measures segment instruction and cycle counts between start and stop marker instructions. All results are registered, and errors are sticky so the bench or a debug CSR can read them after the run.

## Interface
- NRET, 2: commit lanes per cycle, 1..4; lane 0 is oldest
- CNT_W, 48: width of the segment instruction and cycle counters
- START_INST, 32'h00102013: segment start marker
- STOP_INST, 32'h00202013: segment stop marker
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset (0 = reset)
- valid  in  NRET  per-lane commit valid
- order  in  NRET*64  per-lane retirement order
- inst  in  NRET*32  per-lane instruction word
- pc_rdata / pc_wdata  in  NRET*32 each  per-lane PC and next PC
- mem_rmask / mem_wmask  in  NRET*4 each  per-lane byte masks
- halt  out  1  sticky: a halt idiom has been committed
- err_code  out  4  sticky error bits: [0] lane gap, [1] order mismatch, [2] PC chain break, [3] rmask and wmask both nonzero
- err_order  out  64  order of the first offending lane
- seg_inst  out  CNT_W  instructions counted in the segment
- seg_cycles  out  CNT_W  cycles counted in the segment
- seg_active  out  1  segment currently counting
- seg_done  out  1  one-cycle pulse, the cycle after the stop marker is counted

## Operation
- Tracker FSM: WAIT_FIRST -> RUN on the first cycle with any valid; RUN -> HALTED when a halt idiom commits; HALTED is left only by reset.
- Valid lanes are walked from lane 0 upward; a "previous lane" is the previous valid lane in that order.
- Lane packing: valid must be contiguous from lane 0. Any valid[i]=1 with valid[i-1]=0 sets err_code[0]. Checks below use only lane 0 through the last contiguous valid lane.
- Order: the expected order exp_order resets to 0. Lane i must carry exp_order+i; otherwise set err_code[1]. exp_order advances by the contiguous valid count each cycle, even after a mismatch.
- PC chain: each lane's pc_rdata must equal the previous lane's pc_wdata, or, for lane 0, last_pc_wdata from the latest prior commit cycle. The check is skipped for lane 0 in WAIT_FIRST. A mismatch sets err_code[2].
- Mask check: a lane with both masks nonzero sets err_code[3].
- err_order captures the lowest offending lane's order only when err_code was 0 before this cycle. Later errors OR into err_code; err_order holds.
- Halt idiom: pc_rdata==pc_wdata, or inst equal to 32'h00000063, 32'h0000006f or 32'hF0002013. It sets halt. Lanes after the halting lane in the same cycle are still checked and counted.
- Segment FSM:
  - States are SEG_OFF, SEG_ON and SEG_DONE.
  - START_INST in lane s, in any state, clears both counters. Only lanes after s count in that cycle; seg_cycles becomes 0; next state is SEG_ON.
  - In SEG_ON, each cycle adds 1 to seg_cycles and adds the number of counted valid lanes to seg_inst.
  - STOP_INST in SEG_ON is counted, including its own lane and cycle. Later lanes are not counted. The FSM goes to SEG_DONE and pulses seg_done.
  - In SEG_DONE and SEG_OFF the counters hold.
  - If START_INST and STOP_INST commit in the same cycle, they are resolved in lane order: a start in a later lane than the stop restarts the segment.
- Counters saturate at all-ones and do not wrap.

## Timing
- Every output is registered and reflects commits with 1-cycle latency.
- Reset values:
  - halt=0, err_code=0, err_order=0
  - seg_inst=0, seg_cycles=0, seg_active=0, seg_done=0
  - exp_order=0, last_pc_wdata=0
  - FSMs in WAIT_FIRST and SEG_OFF
- Reset asserted mid-segment or mid-run clears all state at that edge. Inputs are ignored while rst=0.
- seg_active=1 exactly while the segment FSM is in SEG_ON.
- There is no back-pressure; every valid lane is consumed in the cycle it is presented.

## Test plan
- NRET=2; 10 cycles of dual commits with orders 0..19 and a consistent PC chain -> err_code=0, exp_order=20, halt=0.
- valid=2'b10 in one cycle -> next cycle err_code=4'b0001, err_order = lane-1's order.
- Lane 0 order 5 when 4 is expected -> err_code[1]=1, err_order=5. A later PC break ORs in err_code[2] while err_order stays 5.
- Cycle C: lane 1 = START_INST. Commit 1 instruction per cycle for 9 cycles, the last being STOP_INST -> seg_inst=9, seg_cycles=9, seg_done pulses once, seg_active falls.
- Lane 0 = STOP, lane 1 = START in the same cycle during SEG_ON -> the segment restarts, seg_inst=0, seg_active=1, no seg_done.
- inst=32'h0000006f in lane 0 -> halt=1 next cycle. Drive rst=0 for one cycle mid-segment -> all outputs 0, and the FSMs return to WAIT_FIRST and SEG_OFF.
